// File: rtl/snake_pkg.sv
// Shared types and screen/colour constants for the snake datapath.
package snake_pkg;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
    } pos_t;

    typedef enum logic [1:0] {
        RIGHT = 2'd0,
        LEFT  = 2'd1,
        UP    = 2'd2,
        DOWN  = 2'd3
    } dir_t;

    localparam int SCR_W = 160;
    localparam int SCR_H = 120;
    localparam int BLOCK = 2;

    localparam logic [2:0] HEAD = 3'b100;
    localparam logic [2:0] BG   = 3'b000;

endpackage

// File: rtl/snake_body_ram.sv
// Single-port synchronous body-position RAM; read-before-write, one-cycle read latency.
module snake_body_ram #(
    parameter int DEPTH = 2048,
    parameter int AW    = 11,
    parameter int DW    = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] q
);

    logic [DW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Read register: clears on reset, array contents are left alone
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= mem[addr];
        end
    end

endmodule

// File: rtl/snake_datapath.sv
// Snake datapath: head/prev/curr registers, body RAM, wrap arithmetic and the
// registered 2x2 plot output stage driven by the controller's one-hot strobes.
module snake_datapath #(
    parameter int MAX_LEN = 2048,
    parameter int START_X = 80,
    parameter int START_Y = 60,
    parameter int SCR_W   = 160,
    parameter int SCR_H   = 120
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       dir_valid,
    input  logic [1:0] dir,
    input  logic       ld_head,
    input  logic       ld_q_def,
    input  logic       inc_address,
    input  logic       rst_address,
    input  logic       update_head,
    input  logic       ld_head_into_prev,
    input  logic       ld_q_into_curr,
    input  logic       ld_prev_into_q,
    input  logic       ld_curr_into_prev,
    input  logic       draw_q,
    input  logic       draw_curr,
    input  logic [1:0] cnt_status,
    input  logic [2:0] colour_in,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       self_hit
);
    import snake_pkg::*;

    localparam int         AW        = $clog2(MAX_LEN);
    localparam logic [7:0] STEP      = 8'(BLOCK);
    localparam pos_t       START_POS = '{x: 8'(START_X), y: 7'(START_Y)};

    pos_t          head;
    pos_t          prev;
    pos_t          curr;
    pos_t          q;
    pos_t          wdata;
    dir_t          dir_q;
    dir_t          dir_req;
    logic          reversal;
    logic          we;
    logic [AW-1:0] addr;
    logic [AW-1:0] addr_inc;

    function automatic logic [7:0] wrap_step(input logic [7:0] v, input logic dec,
                                             input logic [7:0] lim);
        logic [7:0] v_max;
        v_max = lim - STEP;
        if (dec) begin
            return (v == 8'd0) ? v_max : v - STEP;
        end
        return (v >= v_max) ? 8'd0 : v + STEP;
    endfunction

    function automatic pos_t move_head(input pos_t h, input dir_t d);
        pos_t n;
        n = h;
        case (d)
            RIGHT:   n.x = wrap_step(h.x, 1'b0, 8'(SCR_W));
            LEFT:    n.x = wrap_step(h.x, 1'b1, 8'(SCR_W));
            UP:      n.y = 7'(wrap_step({1'b0, h.y}, 1'b1, 8'(SCR_H)));
            default: n.y = 7'(wrap_step({1'b0, h.y}, 1'b0, 8'(SCR_H)));
        endcase
        return n;
    endfunction

    // Initial body lays segments leftwards from the start position, wrapping on x
    function automatic logic [7:0] default_x(input logic [AW-1:0] a);
        int t;
        t = (START_X - BLOCK * int'(a)) % SCR_W;
        if (t < 0) begin
            t = t + SCR_W;
        end
        return 8'(t);
    endfunction

    assign dir_req  = dir_t'(dir);
    assign reversal = ((dir_req ^ dir_q) == 2'b01);
    assign addr_inc = (addr == AW'(MAX_LEN - 1)) ? '0 : addr + AW'(1);

    always_comb begin
        we    = 1'b0;
        wdata = prev;
        if (!rst) begin
            if (ld_q_def) begin
                we    = 1'b1;
                wdata = '{x: default_x(addr), y: 7'(START_Y)};
            end else if (ld_prev_into_q) begin
                we    = 1'b1;
            end
        end
    end

    snake_body_ram #(
        .DEPTH (MAX_LEN),
        .AW    (AW),
        .DW    ($bits(pos_t))
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .addr  (addr),
        .wdata (wdata),
        .q     (q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            addr     <= '0;
            head     <= START_POS;
            dir_q    <= RIGHT;
            prev     <= '0;
            curr     <= '0;
            self_hit <= 1'b0;
        end else begin
            if (rst_address) begin
                addr <= '0;
            end else if (inc_address || ld_curr_into_prev) begin
                addr <= addr_inc;
            end

            if (ld_head) begin
                head  <= START_POS;
                dir_q <= RIGHT;
            end else begin
                if (update_head) begin
                    head <= move_head(head, dir_q);
                end
                if (dir_valid && !reversal) begin
                    dir_q <= dir_req;
                end
            end

            if (ld_head_into_prev) begin
                prev <= head;
            end else if (ld_curr_into_prev) begin
                prev <= curr;
            end

            if (ld_q_into_curr) begin
                curr <= q;
            end

            if (ld_head) begin
                self_hit <= 1'b0;
            end else if (draw_q && addr != '0 && q == head) begin
                self_hit <= 1'b1;
            end
        end
    end

    // Plot output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            x      <= '0;
            y      <= '0;
            colour <= BG;
            plot   <= 1'b0;
        end else begin
            plot <= draw_q || draw_curr;
            if (draw_q) begin
                x      <= q.x + {7'd0, cnt_status[0]};
                y      <= q.y + {6'd0, cnt_status[1]};
                colour <= (addr == '0) ? HEAD : colour_in;
            end else if (draw_curr) begin
                x      <= curr.x + {7'd0, cnt_status[0]};
                y      <= curr.y + {6'd0, cnt_status[1]};
                colour <= BG;
            end
        end
    end

endmodule
